// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 demux scheduler.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [NUM_CH-1:0] onehot(input sel_t s);
        logic [NUM_CH-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin lane search: first enabled lane after cur, scanning cyclically.
module rr_next_sel
    import demux_pkg::*;
(
    input  sel_t              cur,
    input  logic [NUM_CH-1:0] en,
    output sel_t              nxt,
    output logic              found
);

    sel_t cand;

    // cur itself is excluded, so found=0 means no other lane is enabled
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = cur;
        for (int unsigned k = 1; k < NUM_CH; k++) begin
            cand = cur + sel_t'(k);
            if (!found && en[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1_4_sched.sv
// Valid/ready front end steering each beat to one of four lanes, fixed or
// round-robin in bursts, through one registered output stage.
module demux_1_4_sched
    import demux_pkg::*;
#(
    parameter int unsigned W     = 1,
    parameter int unsigned BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [NUM_CH-1:0]     chan_en,
    output logic [NUM_CH-1:0]     out_valid,
    output logic [NUM_CH*W-1:0]   out_data,
    input  logic [NUM_CH-1:0]     out_ready,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(BURST) + 1;

    sel_t                  route_q, route_d;
    sel_t                  hold_q, hold_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [NUM_CH-1:0]     valid_q, valid_d;
    logic [NUM_CH*W-1:0]   data_q, data_d;

    sel_t rr_nxt;
    logic rr_found;
    sel_t adv_sel;
    logic lane_en, burst_start, last_beat, ok_route, sink_free, accept, drain;

    rr_next_sel u_rr_next_sel (
        .cur   (route_q),
        .en    (chan_en),
        .nxt   (rr_nxt),
        .found (rr_found)
    );

    always_comb begin
        lane_en     = chan_en[route_q];
        burst_start = (count_q == '0);
        last_beat   = (count_q == CNT_W'(BURST - 1));
        // mode/cfg_sel only matter at a burst boundary; mid-burst keeps its lane
        ok_route    = lane_en && (!burst_start || (mode == MODE_RR) || (route_q == cfg_sel));
        sink_free   = (valid_q == '0) || out_ready[hold_q];
        in_ready    = rst_n && ok_route && sink_free;
        accept      = in_valid && in_ready;
        drain       = (valid_q != '0) && out_ready[hold_q];
        adv_sel     = (mode == MODE_RR) ? (rr_found ? rr_nxt : route_q) : cfg_sel;
    end

    always_comb begin
        route_d = route_q;
        hold_d  = hold_q;
        count_d = count_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d                    = onehot(route_q);
            hold_d                     = route_q;
            data_d                     = '0;
            data_d[route_q*W +: W]     = in_data;
            if (last_beat) begin
                count_d = '0;
                route_d = adv_sel;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else begin
            if (drain) begin
                valid_d = '0;
                data_d  = '0;
            end
            if (!burst_start && !lane_en) begin
                // lane pulled mid-burst: abandon the burst and move on
                count_d = '0;
                route_d = adv_sel;
            end else if (burst_start) begin
                if (mode == MODE_FIXED) begin
                    route_d = cfg_sel;
                end else if (!lane_en && rr_found) begin
                    route_d = rr_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            route_q <= '0;
            hold_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            route_q <= route_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign cur_sel   = route_q;
    assign busy      = (valid_q != '0) || (count_q != '0);

endmodule
